rxuart_frontend: RTL and testbench
==================================

// Module: rxuart_frontend
// PURPOSE
// - 8N1 UART receive front end: synchronises i_uart_rx, finds start bits, samples mid-bit, emits one byte strobe.
// - Sits directly upstream of the wbuart RX FIFO; o_wr/o_data drive the FIFO write port (rx_stb/rx_uart_data).
// - Also reports framing errors and line-break conditions for the RX status bits.
// PARAMETERS
// - CW        24   width of baud divisor (i_setup)
// - MIN_BAUD  16   smallest honoured clocks-per-baud; smaller i_setup values are treated as MIN_BAUD
// PORTS
// - i_clk        in   1    system clock, all logic on rising edge
// - i_reset      in   1    asynchronous, active-high reset
// - i_setup      in   CW   clocks per baud bit (same meaning as the wbuart setup register low field)
// - i_uart_rx    in   1    raw serial input, idle high, asynchronous to i_clk
// - o_wr         out  1    one-cycle strobe: o_data holds a valid received byte
// - o_data       out  8    received byte, LSB first on the wire; held until next o_wr
// - o_frame_err  out  1    one-cycle strobe: stop bit sampled low
// - o_break      out  1    level: line held low through a whole all-zero frame; clears when line returns high
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, baud counter=0, bit index=0, shift reg=0, both sync flops=1,
//   o_wr=0, o_data=8'h00, o_frame_err=0, o_break=0. Frame in progress is discarded; no strobe on release.
// - Sync: 2-flop chain, rx_s = second flop. All decisions use rx_s only (2-cycle input latency).
// - Divisor latched into baud_q at start-edge detection; i_setup changes mid-frame have no effect until next frame.
// - Counter: down-counter; a "tick" is the cycle counter==0; on tick reload baud_q-1.
// - States:
//   IDLE : rx_s==0 -> load counter=(baud_q>>1)-1, go START.
//   START: tick with rx_s==0 -> bit index=0, go DATA; tick with rx_s==1 -> glitch, go IDLE, no outputs.
//   DATA : each tick shift rx_s into MSB (shift right); after 8th tick go STOP.
//   STOP : tick with rx_s==1 -> o_wr=1, o_data=shift reg, go IDLE (same cycle may not detect new start;
//          IDLE checks next cycle). tick with rx_s==0 -> o_frame_err=1, no o_wr;
//          if shift reg==0 go BREAK with o_break=1, else go IDLE.
//   BREAK: wait for rx_s==1, then o_break=0, go IDLE. No further o_frame_err while in BREAK.
// - Sample point: centre of each bit = start edge + baud_q/2 + k*baud_q cycles (k=1..9 for data/stop).
// - Latency: o_wr asserts baud_q/2 + 9*baud_q (+/-1) cycles after rx_s falls, i.e. mid stop bit.
// - Back-to-back frames (no idle gap) must be received: IDLE reached by mid stop bit, next start edge
//   arrives half a bit later.
// - o_wr and o_frame_err are never high in the same cycle; each is high at most one cycle per frame.
// - Framing-error IDLE return: if rx_s still 0, IDLE immediately treats it as a new start edge (resync).
// - No overrun handling here: downstream FIFO must accept o_wr every cycle it is asserted.
// TESTING
// - i_setup=25, send 0x1E (8N1) -> exactly one o_wr, o_data=8'h1E, o_frame_err=0, o_wr ~240 cycles after start edge.
// - i_setup=25, rx low for 5 cycles then high -> no o_wr, no o_frame_err, state back to IDLE within 15 cycles.
// - i_setup=25, send 0x55 with stop bit forced low -> one o_frame_err pulse, no o_wr, o_break stays 0.
// - Hold rx low 30 bit times, then release -> one o_frame_err, o_break=1 until 2-3 cycles after release,
//   then send 0xA5 -> o_wr with o_data=8'hA5.
// - Send 0x00 then 0xFF back-to-back, no idle -> two o_wr strobes, data 8'h00 then 8'hFF, no errors.
// - Assert i_reset during data bit 4 of a frame, release, send 0x3C -> all outputs 0 during reset, no strobe
//   for aborted frame, then one o_wr with o_data=8'h3C.

Source files
------------

// File: rtl/rxuart_frontend.sv
// rxuart_frontend
// 8N1 UART receive front end. Synchronises the raw serial line, detects
// start edges, samples each bit at its centre and emits a one-cycle byte
// strobe that feeds the RX FIFO write port. It also flags framing errors and
// holds a break indication while the line sits low after an all-zero frame.
module rxuart_frontend #(
    parameter int CW       = 24,
    parameter int MIN_BAUD = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [CW-1:0] i_setup,
    input  logic          i_uart_rx,
    output logic          o_wr,
    output logic [7:0]    o_data,
    output logic          o_frame_err,
    output logic          o_break
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // Divisors below the floor are clamped so the half-bit load stays sane.
    function automatic logic [CW-1:0] clamp_baud(input logic [CW-1:0] setup);
        if (setup < CW'(MIN_BAUD)) begin
            return CW'(MIN_BAUD);
        end else begin
            return setup;
        end
    endfunction

    logic          sync_1;
    logic          rx_s;
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] baud_q;
    logic [CW-1:0] baud_next;
    logic [CW-1:0] counter;
    logic [CW-1:0] counter_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          wr_next;
    logic [7:0]    data_next;
    logic          ferr_next;
    logic          break_next;
    logic          tick;
    logic [CW-1:0] setup_eff;

    assign tick      = (counter == {CW{1'b0}});
    assign setup_eff = clamp_baud(i_setup);

    // Two-flop synchroniser for the asynchronous serial input; idles high.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= i_uart_rx;
            rx_s   <= sync_1;
        end
    end

    // Next-state, counter, shift register and output decode for the receiver.
    always_comb begin
        state_next   = state;
        baud_next    = baud_q;
        counter_next = tick ? (baud_q - CW'(1)) : (counter - CW'(1));
        bit_idx_next = bit_idx;
        shift_next   = shift;
        wr_next      = 1'b0;
        data_next    = o_data;
        ferr_next    = 1'b0;
        break_next   = o_break;

        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    // Latch the divisor now so mid-frame setup changes are ignored.
                    baud_next    = setup_eff;
                    counter_next = (setup_eff >> 1) - CW'(1);
                    state_next   = S_START;
                end else begin
                    counter_next = {CW{1'b0}};
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        bit_idx_next = 3'd0;
                        state_next   = S_DATA;
                    end else begin
                        // Line went back high before mid start bit: glitch.
                        state_next = S_IDLE;
                    end
                end else begin
                    state_next = S_START;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_next = {rx_s, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    state_next = S_DATA;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        wr_next    = 1'b1;
                        data_next  = shift;
                        state_next = S_IDLE;
                    end else begin
                        ferr_next = 1'b1;
                        if (shift == 8'h00) begin
                            break_next = 1'b1;
                            state_next = S_BREAK;
                        end else begin
                            // IDLE resyncs if the line is still low next cycle.
                            state_next = S_IDLE;
                        end
                    end
                end else begin
                    state_next = S_STOP;
                end
            end
            S_BREAK: begin
                counter_next = {CW{1'b0}};
                if (rx_s) begin
                    break_next = 1'b0;
                    state_next = S_IDLE;
                end else begin
                    state_next = S_BREAK;
                end
            end
            default: begin
                counter_next = {CW{1'b0}};
                break_next   = 1'b0;
                state_next   = S_IDLE;
            end
        endcase
    end

    // Receiver state, timing and datapath registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= S_IDLE;
            baud_q  <= CW'(MIN_BAUD);
            counter <= {CW{1'b0}};
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            state   <= state_next;
            baud_q  <= baud_next;
            counter <= counter_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    // Registered strobes, byte and break level toward the FIFO and status bits.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_wr        <= 1'b0;
            o_data      <= 8'h00;
            o_frame_err <= 1'b0;
            o_break     <= 1'b0;
        end else begin
            o_wr        <= wr_next;
            o_data      <= data_next;
            o_frame_err <= ferr_next;
            o_break     <= break_next;
        end
    end

endmodule

// File: tb/tb_rxuart_frontend.sv
// Testbench for rxuart_frontend: serial frames are generated at bit level,
// expected events go into a scoreboard queue, a monitor checks DUT strobes.
module tb_rxuart_frontend;

    localparam int CW = 24;

    logic          clk;
    logic          rst;
    logic [CW-1:0] setup;
    logic          rx;
    logic          o_wr;
    logic [7:0]    o_data;
    logic          o_frame_err;
    logic          o_break;

    typedef struct {
        bit         is_wr;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  total;
    int  bad;
    int  cyc;
    int  last_wr_cyc;

    rxuart_frontend #(.CW(CW), .MIN_BAUD(16)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_setup    (setup),
        .i_uart_rx  (rx),
        .o_wr       (o_wr),
        .o_data     (o_data),
        .o_frame_err(o_frame_err),
        .o_break    (o_break)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Bit time the receiver should use for a given setup value.
    function automatic int eff_baud(input int s);
        return (s < 16) ? 16 : s;
    endfunction

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Send one 8N1 frame. A bad stop bit is held low for 3/4 of a bit, then high.
    // With perturb, i_setup is scrambled mid-frame and restored at the end.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int b, input bit perturb);
        logic [CW-1:0] saved;
        saved = setup;
        hold(1'b0, b / 2);
        if (perturb) setup = CW'($urandom_range(0, 60));
        hold(1'b0, b - b / 2);
        for (int i = 0; i < 8; i++) hold(d[i], b);
        if (stop_ok) begin
            hold(1'b1, b);
        end else begin
            hold(1'b0, (3 * b) / 4);
            hold(1'b1, b - (3 * b) / 4);
        end
        setup = saved;
    endtask

    task automatic expect_wr(input logic [7:0] d);
        ev_t e;
        e.is_wr = 1'b1;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_ferr();
        ev_t e;
        e.is_wr = 1'b0;
        e.data  = 8'h00;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_wr && o_frame_err) begin
                total++;
                bad++;
                $display("FAIL both_strobes actual=wr1_ferr1 required=at_most_one");
            end
            if (o_wr || o_frame_err) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event actual=wr%0b_ferr%0b_data%02h required=none",
                             o_wr, o_frame_err, o_data);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if ((o_wr != e.is_wr) || (e.is_wr && (o_data !== e.data))) begin
                        bad++;
                        $display("FAIL event actual=wr%0b_data%02h required=wr%0b_data%02h",
                                 o_wr, o_data, e.is_wr, e.data);
                    end
                end
                if (o_wr) last_wr_cyc = cyc;
            end
        end
    end

    initial begin
        int c0;
        int b;
        int s;
        int gap;
        bit ok;
        logic [7:0] d;

        total = 0;
        bad   = 0;
        cyc   = 0;
        last_wr_cyc = 0;
        rst   = 1'b1;
        rx    = 1'b1;
        setup = CW'(25);
        repeat (3) @(negedge clk);
        check("reset_wr",    {31'd0, o_wr},        32'd0);
        check("reset_data",  {24'd0, o_data},      32'd0);
        check("reset_ferr",  {31'd0, o_frame_err}, 32'd0);
        check("reset_break", {31'd0, o_break},     32'd0);
        rst = 1'b0;
        hold(1'b1, 10);

        // Single frame 0x1E with latency check from the raw start edge.
        expect_wr(8'h1E);
        c0 = cyc;
        send_frame(8'h1E, 1'b1, 25, 1'b0);
        hold(1'b1, 25);
        check("latency_1e", {31'd0, ((last_wr_cyc - c0) >= 236) && ((last_wr_cyc - c0) <= 244)}, 32'd1);

        // Short glitch: must be rejected with no strobes.
        hold(1'b0, 5);
        hold(1'b1, 15);

        // Framing error on a nonzero byte: no break.
        expect_ferr();
        send_frame(8'h55, 1'b0, 25, 1'b0);
        hold(1'b1, 50);
        check("ferr_no_break", {31'd0, o_break}, 32'd0);

        // Long low line: one framing error then break until the line returns.
        expect_ferr();
        hold(1'b0, 30 * 25);
        check("break_set", {31'd0, o_break}, 32'd1);
        hold(1'b1, 1);
        check("break_held", {31'd0, o_break}, 32'd1);
        hold(1'b1, 3);
        check("break_clear", {31'd0, o_break}, 32'd0);
        hold(1'b1, 50);
        expect_wr(8'hA5);
        send_frame(8'hA5, 1'b1, 25, 1'b0);

        // Back-to-back frames with no idle gap.
        expect_wr(8'h00);
        expect_wr(8'hFF);
        send_frame(8'h00, 1'b1, 25, 1'b0);
        send_frame(8'hFF, 1'b1, 25, 1'b0);
        hold(1'b1, 25);

        // Reset in the middle of data bit 4 of an aborted frame.
        d = 8'h96;
        hold(1'b0, 25);
        for (int i = 0; i < 4; i++) hold(d[i], 25);
        hold(d[4], 12);
        rst = 1'b1;
        hold(1'b1, 3);
        check("rst_mid_wr",    {31'd0, o_wr},        32'd0);
        check("rst_mid_data",  {24'd0, o_data},      32'd0);
        check("rst_mid_ferr",  {31'd0, o_frame_err}, 32'd0);
        check("rst_mid_break", {31'd0, o_break},     32'd0);
        rst = 1'b0;
        hold(1'b1, 50);
        expect_wr(8'h3C);
        send_frame(8'h3C, 1'b1, 25, 1'b0);
        hold(1'b1, 25);

        // Randomised frames: varied divisors (including clamped ones), gaps,
        // bad stop bits and mid-frame setup perturbation.
        for (int n = 0; n < 24; n++) begin
            s = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 40);
            b = eff_baud(s);
            setup = CW'(s);
            d  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 4) != 0);
            if (ok) expect_wr(d);
            else    expect_ferr();
            send_frame(d, ok, b, $urandom_range(0, 1) == 1);
            gap = ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
            hold(1'b1, gap * b);
        end

        hold(1'b1, 100);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
